clock_enable_gen: RTL
=====================

Name: clock_enable_gen

Overview:
- Parametrised successor to the fixed 48 MHz clock block.
- Takes the single buffered system clock and produces NUM_CH independent, run-time programmable clock-enable ticks plus divided square-wave outputs.
- Produces a power-on "ready" qualifier so downstream logic never sees ticks before the clock tree is settled.
- Sits directly after the clock buffer; all other RTL uses its ticks instead of derived clocks.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_W, 16, width of each divisor value.
- DEFAULT_DIV, 48, divisor loaded into every channel at reset (48 gives a 1 MHz tick from 48 MHz).
- RST_HOLD, 16, clk cycles after reset release before ready asserts (>=1).

Ports:
- clk  in  1  system clock (48 MHz).
- reset  in  1  synchronous, active-high reset.
- div_wr  in  1  single-cycle write strobe for a divisor.
- div_sel  in  $clog2(NUM_CH) (min 1)  channel addressed by div_wr.
- div_val  in  DIV_W  new divisor; value 0 treated as 1.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_req  in  1  realign all channel phases.
- tick  out  NUM_CH  one-cycle enable pulse, once every divisor cycles.
- div_clk  out  NUM_CH  square wave; toggles on each tick (period 2*divisor).
- ready  out  1  high once RST_HOLD cycles have elapsed since reset release.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state is updated on the rising edge of clk only.
- Reset values:
  - tick=0, div_clk=0, ready=0.
  - hold counter = 0.
  - Per channel: active divisor = shadow divisor = DEFAULT_DIV; counter = DEFAULT_DIV-1.
- Ready sequencing:
  - The hold counter increments each cycle while ready=0.
  - ready goes high on the cycle after the counter reaches RST_HOLD-1, i.e. RST_HOLD cycles after the first cycle with reset=0.
  - ready stays high until the next reset. While ready=0, tick and div_clk are held at 0 and the counters are held at reload.
- Per channel, when ready=1 and ch_en[i]=1:
  - The counter decrements each cycle.
  - When the counter is 0: tick[i]=1 for that cycle, div_clk[i] inverts, and the counter reloads with (shadow divisor - 1); shadow is copied into active at that moment.
  - The first tick after enable occurs divisor cycles after ch_en rises.
- ch_en[i]=0: counter forced to active divisor - 1, tick[i]=0, div_clk[i] holds its current level.
- Divisor writes:
  - div_wr stores div_val (0 -> 1) into the shadow register of channel div_sel.
  - The new value takes effect only at the next wrap, so no runt or shortened period.
  - A write in the same cycle as a wrap is used for that wrap's reload.
  - A write with div_sel >= NUM_CH is ignored.
  - A write to a disabled channel takes effect immediately on its reload value.
- Divisor 1: tick continuously high while enabled; div_clk toggles every cycle.
- sync_req=1 (requires ready=1):
  - All counters reload from shadow - 1; shadow is copied into active.
  - div_clk is cleared to 0 and tick is 0 in that cycle.
  - sync_req has priority over a wrap in the same cycle.
  - A div_wr in the same cycle is applied first, so the new value is used.
- reset asserted mid-operation: next edge restores all reset values; any in-flight period is discarded.
- Width rule: counters are DIV_W bits; there is no overflow because the reload value is always <= 2^DIV_W-1.

Decomposition:
- Shared package clock_pkg:
  - Default constants: CLK_HZ=48_000_000, DEFAULT_DIV, RST_HOLD.
  - Divisor typedef of width DIV_W.
  - Helper for the div_sel width (max(1, clog2(NUM_CH))).
- One sub-module, clock_div_channel: counter, shadow/active divisor, tick and div_clk for a single channel. It is instantiated NUM_CH times in a generate loop.
- The top level holds the ready sequencer and the write decode.

Test Plan:
- Reset release with RST_HOLD=16 -> ready rises exactly 16 cycles after reset falls; tick stays 0 throughout.
- Default divisor 48, ch_en=0001 after ready -> tick[0] pulses every 48 cycles, first pulse 48 cycles after enable; div_clk[0] has a 96-cycle period; the other channels stay 0.
- Write div_val=10 to channel 2 mid-period of a 48 divisor -> the current period completes at 48 cycles, then ticks every 10; no short period.
- Write div_val=0 and div_val=1 -> tick held high continuously; div_clk toggles every cycle.
- sync_req while channels with divisors 3/5/7 are running -> all div_clk=0 that cycle; next ticks at +3/+5/+7 cycles exactly.
- Reset asserted mid-period with div_wr in the same cycle -> the write is lost; divisors return to 48; ready=0; outputs 0 the following cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants, types and helpers for the clock-enable generator.
package clock_pkg;

    // Nominal system clock feeding the generator.
    localparam int CLK_HZ         = 48_000_000;
    // Divisor loaded at reset: 48 MHz / 48 = 1 MHz tick.
    localparam int DEFAULT_DIV_C  = 48;
    // Cycles between reset release and ready.
    localparam int RST_HOLD_C     = 16;
    // Default divisor width.
    localparam int DIV_W_C        = 16;

    // Divisor value at the default width.
    typedef logic [DIV_W_C-1:0] divisor_t;

    // What a channel does on the coming edge.
    typedef enum logic [2:0] {
        ACT_HOLD  = 3'd0,   // clock tree not settled: held at reload
        ACT_SYNC  = 3'd1,   // global phase realignment
        ACT_IDLE  = 3'd2,   // channel disabled
        ACT_WRAP  = 3'd3,   // counter reached zero: tick and reload
        ACT_COUNT = 3'd4    // normal decrement
    } ch_action_e;

    // Ready sequencer states.
    typedef enum logic [0:0] {
        SEQ_HOLD = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    // Width of the channel-select field; at least one bit.
    function automatic int sel_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: down-counter with shadow/active divisor pair,
// one-cycle tick pulse and a square wave toggling on every tick.
module clock_div_channel
    import clock_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_val,
    output logic             tick,
    output logic             div_clk
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] ZERO      = {DIV_W{1'b0}};

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] active_r;
    logic [DIV_W-1:0] shadow_r;
    logic             tick_r;
    logic             div_clk_r;

    logic [DIV_W-1:0] shadow_next_s;
    ch_action_e       action_s;

    // A write in this cycle is visible to any reload happening in this cycle.
    always_comb begin
        shadow_next_s = shadow_r;
        if (wr) begin
            shadow_next_s = wr_val;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // Pick the channel action; sync outranks a wrap, ready gates everything.
    always_comb begin
        action_s = ACT_HOLD;
        if (!ready) begin
            action_s = ACT_HOLD;
        end else if (sync) begin
            action_s = ACT_SYNC;
        end else if (!en) begin
            action_s = ACT_IDLE;
        end else if (cnt_r == ZERO) begin
            action_s = ACT_WRAP;
        end else begin
            action_s = ACT_COUNT;
        end
    end

    // Counter, divisor registers and registered tick/div_clk outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= RESET_DIV - ONE;
            active_r  <= RESET_DIV;
            shadow_r  <= RESET_DIV;
            tick_r    <= 1'b0;
            div_clk_r <= 1'b0;
        end else begin
            shadow_r <= shadow_next_s;
            case (action_s)
                ACT_HOLD: begin
                    // Settles on the latest divisor one cycle after a write.
                    cnt_r     <= active_r - ONE;
                    active_r  <= shadow_next_s;
                    tick_r    <= 1'b0;
                    div_clk_r <= 1'b0;
                end
                ACT_SYNC: begin
                    cnt_r     <= shadow_next_s - ONE;
                    active_r  <= shadow_next_s;
                    tick_r    <= 1'b0;
                    div_clk_r <= 1'b0;
                end
                ACT_IDLE: begin
                    // Disabled: a new divisor applies straight away.
                    cnt_r     <= shadow_next_s - ONE;
                    active_r  <= shadow_next_s;
                    tick_r    <= 1'b0;
                    div_clk_r <= div_clk_r;
                end
                ACT_WRAP: begin
                    cnt_r     <= shadow_next_s - ONE;
                    active_r  <= shadow_next_s;
                    tick_r    <= 1'b1;
                    div_clk_r <= ~div_clk_r;
                end
                ACT_COUNT: begin
                    cnt_r     <= cnt_r - ONE;
                    active_r  <= active_r;
                    tick_r    <= 1'b0;
                    div_clk_r <= div_clk_r;
                end
                default: begin
                    cnt_r     <= active_r - ONE;
                    active_r  <= active_r;
                    tick_r    <= 1'b0;
                    div_clk_r <= 1'b0;
                end
            endcase
        end
    end

    assign tick    = tick_r;
    assign div_clk = div_clk_r;

endmodule

// File: rtl/clock_enable_gen.sv
// Clock-enable generator: ready sequencer after reset, divisor write
// decode, and NUM_CH independent divider channels.
module clock_enable_gen
    import clock_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = DEFAULT_DIV_C,
    parameter int RST_HOLD    = RST_HOLD_C
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         div_wr,
    input  logic [sel_width(NUM_CH)-1:0] div_sel,
    input  logic [DIV_W-1:0]             div_val,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic                         sync_req,
    output logic [NUM_CH-1:0]            tick,
    output logic [NUM_CH-1:0]            div_clk,
    output logic                         ready
);

    localparam int SEL_W  = sel_width(NUM_CH);
    localparam int HOLD_W = (RST_HOLD <= 1) ? 1 : $clog2(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    seq_state_e          seq_r;
    logic [HOLD_W-1:0]   hold_r;
    logic                ready_r;

    logic [NUM_CH-1:0]   wr_s;
    logic [DIV_W-1:0]    wr_val_s;
    logic                sync_s;

    // Ready sequencer: count settle cycles, then stay ready until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_r   <= SEQ_HOLD;
            hold_r  <= {HOLD_W{1'b0}};
            ready_r <= 1'b0;
        end else begin
            case (seq_r)
                SEQ_HOLD: begin
                    if (hold_r == HOLD_LAST) begin
                        seq_r   <= SEQ_RUN;
                        hold_r  <= hold_r;
                        ready_r <= 1'b1;
                    end else begin
                        seq_r   <= SEQ_HOLD;
                        hold_r  <= hold_r + HOLD_W'(1);
                        ready_r <= 1'b0;
                    end
                end
                SEQ_RUN: begin
                    seq_r   <= SEQ_RUN;
                    hold_r  <= hold_r;
                    ready_r <= 1'b1;
                end
                default: begin
                    seq_r   <= SEQ_HOLD;
                    hold_r  <= {HOLD_W{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Divisor write decode; zero is promoted to one, unmatched selects drop.
    always_comb begin
        wr_s     = {NUM_CH{1'b0}};
        wr_val_s = div_val;
        if (div_val == {DIV_W{1'b0}}) begin
            wr_val_s = DIV_W'(1);
        end else begin
            wr_val_s = div_val;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (div_wr && (div_sel == SEL_W'(i))) begin
                wr_s[i] = 1'b1;
            end else begin
                wr_s[i] = 1'b0;
            end
        end
    end

    // Realignment only acts once the clock tree is settled.
    always_comb begin
        sync_s = 1'b0;
        if (ready_r) begin
            sync_s = sync_req;
        end else begin
            sync_s = 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .ready   (ready_r),
            .en      (ch_en[g]),
            .sync    (sync_s),
            .wr      (wr_s[g]),
            .wr_val  (wr_val_s),
            .tick    (tick[g]),
            .div_clk (div_clk[g])
        );
    end

    assign ready = ready_r;

endmodule
